wb_arbiter: RTL and testbench

Writeback arbiter and retire sequencer for the NPC core's single register-file write port. It takes completed results from the EXU path (ALU, JAL/JALR link values) and the LSU path (load data, variable latency) and grants at most one per cycle with round-robin fairness. It registers the winner into the regfile write port and emits a per-instruction retire pulse and counters for difftest and performance tracking. It sits between the EXU/LSU outputs and the GPR file, downstream of the writeback data select.

---
 rtl/wb_arbiter.sv | 125 ++++++++++++
 tb/tb_wb_arbiter.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/wb_arbiter.sv
// wb_arbiter: round-robin writeback arbiter for the single regfile write port.
// Grants one of EXU/LSU per cycle, registers the winner onto the regfile port
// and produces a retire pulse plus a retire counter.
// Optional: define WB_PERF_EN to build the conflict_cnt performance counter.
module wb_arbiter #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            exu_valid,
    output logic            exu_ready,
    input  logic [RA_W-1:0] exu_rd,
    input  logic [XLEN-1:0] exu_data,
    input  logic [XLEN-1:0] exu_pc,
    input  logic            lsu_valid,
    output logic            lsu_ready,
    input  logic [RA_W-1:0] lsu_rd,
    input  logic [XLEN-1:0] lsu_data,
    input  logic [XLEN-1:0] lsu_pc,
    output logic            rf_wen,
    output logic [RA_W-1:0] rf_waddr,
    output logic [XLEN-1:0] rf_wdata,
    output logic            retire_valid,
    output logic [XLEN-1:0] retire_pc,
    output logic [31:0]     retire_cnt,
    output logic [31:0]     conflict_cnt
);

    typedef enum logic {PrioLsu = 1'b0, PrioExu = 1'b1} prio_e;

    prio_e           prio_q, prio_d;
    logic            rf_wen_q, rf_wen_d;
    logic [RA_W-1:0] rf_waddr_q, rf_waddr_d;
    logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
    logic            retire_valid_q, retire_valid_d;
    logic [XLEN-1:0] retire_pc_q, retire_pc_d;
    logic [31:0]     retire_cnt_q, retire_cnt_d;
    logic            exu_hs, lsu_hs;

    // Grant decode: a side loses only when the other is valid and holds priority.
    always_comb begin
        exu_ready = !flush && !(lsu_valid && prio_q == PrioLsu);
        lsu_ready = !flush && !(exu_valid && prio_q == PrioExu);
        exu_hs    = exu_valid && exu_ready;
        lsu_hs    = lsu_valid && lsu_ready;
    end

    // Next-state: capture the winner, pulse retire, rotate priority.
    always_comb begin
        prio_d         = prio_q;
        rf_wen_d       = 1'b0;
        rf_waddr_d     = rf_waddr_q;
        rf_wdata_d     = rf_wdata_q;
        retire_valid_d = 1'b0;
        retire_pc_d    = retire_pc_q;
        retire_cnt_d   = retire_cnt_q;
        if (flush) begin
            prio_d = PrioLsu;
        end else if (lsu_hs) begin
            prio_d         = PrioExu;
            rf_wen_d       = (lsu_rd != '0);
            rf_waddr_d     = lsu_rd;
            rf_wdata_d     = lsu_data;
            retire_valid_d = 1'b1;
            retire_pc_d    = lsu_pc;
            retire_cnt_d   = retire_cnt_q + 32'd1;
        end else if (exu_hs) begin
            prio_d         = PrioLsu;
            rf_wen_d       = (exu_rd != '0);
            rf_waddr_d     = exu_rd;
            rf_wdata_d     = exu_data;
            retire_valid_d = 1'b1;
            retire_pc_d    = exu_pc;
            retire_cnt_d   = retire_cnt_q + 32'd1;
        end
    end

    // State registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prio_q         <= PrioLsu;
            rf_wen_q       <= 1'b0;
            rf_waddr_q     <= '0;
            rf_wdata_q     <= '0;
            retire_valid_q <= 1'b0;
            retire_pc_q    <= '0;
            retire_cnt_q   <= '0;
        end else begin
            prio_q         <= prio_d;
            rf_wen_q       <= rf_wen_d;
            rf_waddr_q     <= rf_waddr_d;
            rf_wdata_q     <= rf_wdata_d;
            retire_valid_q <= retire_valid_d;
            retire_pc_q    <= retire_pc_d;
            retire_cnt_q   <= retire_cnt_d;
        end
    end

    assign rf_wen       = rf_wen_q;
    assign rf_waddr     = rf_waddr_q;
    assign rf_wdata     = rf_wdata_q;
    assign retire_valid = retire_valid_q;
    assign retire_pc    = retire_pc_q;
    assign retire_cnt   = retire_cnt_q;

`ifdef WB_PERF_EN
    logic [31:0] conflict_cnt_q;

    // Count non-flush cycles where both requesters compete.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conflict_cnt_q <= '0;
        end else if (!flush && exu_valid && lsu_valid) begin
            conflict_cnt_q <= conflict_cnt_q + 32'd1;
        end
    end

    assign conflict_cnt = conflict_cnt_q;
`else
    assign conflict_cnt = '0;
`endif

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter.
module tb_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        exu_valid, exu_ready;
    logic [4:0]  exu_rd;
    logic [31:0] exu_data, exu_pc;
    logic        lsu_valid, lsu_ready;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data, lsu_pc;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        retire_valid;
    logic [31:0] retire_pc, retire_cnt, conflict_cnt;

    int checks = 0;
    int fails  = 0;

`ifdef WB_PERF_EN
    localparam logic [31:0] PerfScale = 32'd1;
`else
    localparam logic [31:0] PerfScale = 32'd0;
`endif

    always #5 clk = ~clk;

    wb_arbiter #(.XLEN(32), .RA_W(5)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .flush        (flush),
        .exu_valid    (exu_valid),
        .exu_ready    (exu_ready),
        .exu_rd       (exu_rd),
        .exu_data     (exu_data),
        .exu_pc       (exu_pc),
        .lsu_valid    (lsu_valid),
        .lsu_ready    (lsu_ready),
        .lsu_rd       (lsu_rd),
        .lsu_data     (lsu_data),
        .lsu_pc       (lsu_pc),
        .rf_wen       (rf_wen),
        .rf_waddr     (rf_waddr),
        .rf_wdata     (rf_wdata),
        .retire_valid (retire_valid),
        .retire_pc    (retire_pc),
        .retire_cnt   (retire_cnt),
        .conflict_cnt (conflict_cnt)
    );

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; flush = 1'b0;
        exu_valid = 1'b0; exu_rd = '0; exu_data = '0; exu_pc = '0;
        lsu_valid = 1'b0; lsu_rd = '0; lsu_data = '0; lsu_pc = '0;
        repeat (3) tick();
        checks++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL reset_rf_wen got %0b want 0", rf_wen); end
        checks++; if (rf_waddr !== 5'd0) begin fails++; $display("FAIL reset_rf_waddr got %0d want 0", rf_waddr); end
        checks++; if (rf_wdata !== 32'd0) begin fails++; $display("FAIL reset_rf_wdata got %h want 0", rf_wdata); end
        checks++; if (retire_valid !== 1'b0) begin fails++; $display("FAIL reset_retire_valid got %0b want 0", retire_valid); end
        checks++; if (retire_pc !== 32'd0) begin fails++; $display("FAIL reset_retire_pc got %h want 0", retire_pc); end
        checks++; if (retire_cnt !== 32'd0) begin fails++; $display("FAIL reset_retire_cnt got %0d want 0", retire_cnt); end
        checks++; if (conflict_cnt !== 32'd0) begin fails++; $display("FAIL reset_conflict_cnt got %0d want 0", conflict_cnt); end
        rst_n = 1'b1;
        exu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        checks++; if (lsu_ready !== 1'b1) begin fails++; $display("FAIL reset_first_lsu_ready got %0b want 1", lsu_ready); end
        checks++; if (exu_ready !== 1'b0) begin fails++; $display("FAIL reset_first_exu_ready got %0b want 0", exu_ready); end
        exu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
    endtask

    task automatic test_single_exu();
        exu_valid = 1'b1; exu_rd = 5'd5; exu_data = 32'h1234; exu_pc = 32'h8000_0004;
        #1;
        checks++; if (exu_ready !== 1'b1) begin fails++; $display("FAIL single_exu_ready got %0b want 1", exu_ready); end
        tick();
        exu_valid = 1'b0;
        checks++; if (rf_wen !== 1'b1) begin fails++; $display("FAIL single_rf_wen got %0b want 1", rf_wen); end
        checks++; if (rf_waddr !== 5'd5) begin fails++; $display("FAIL single_rf_waddr got %0d want 5", rf_waddr); end
        checks++; if (rf_wdata !== 32'h1234) begin fails++; $display("FAIL single_rf_wdata got %h want 00001234", rf_wdata); end
        checks++; if (retire_valid !== 1'b1) begin fails++; $display("FAIL single_retire_valid got %0b want 1", retire_valid); end
        checks++; if (retire_pc !== 32'h8000_0004) begin fails++; $display("FAIL single_retire_pc got %h want 80000004", retire_pc); end
        checks++; if (retire_cnt !== 32'd1) begin fails++; $display("FAIL single_retire_cnt got %0d want 1", retire_cnt); end
        tick();
        checks++; if (retire_valid !== 1'b0) begin fails++; $display("FAIL single_pulse_end got %0b want 0", retire_valid); end
        checks++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL single_wen_end got %0b want 0", rf_wen); end
        checks++; if (rf_waddr !== 5'd5) begin fails++; $display("FAIL single_waddr_hold got %0d want 5", rf_waddr); end
    endtask

    task automatic test_contention();
        logic [4:0]  exp_rd   [4] = '{5'd10, 5'd20, 5'd11, 5'd21};
        logic [31:0] exp_data [4] = '{32'hA000_0000, 32'hB000_0000, 32'hA000_0001, 32'hB000_0001};
        logic [31:0] exp_pc   [4] = '{32'h100, 32'h200, 32'h104, 32'h204};
        lsu_valid = 1'b1; lsu_rd = 5'd10; lsu_data = 32'hA000_0000; lsu_pc = 32'h100;
        exu_valid = 1'b1; exu_rd = 5'd20; exu_data = 32'hB000_0000; exu_pc = 32'h200;
        for (int i = 0; i < 4; i++) begin
            #1;
            checks++;
            if (lsu_ready !== (i % 2 == 0) || exu_ready !== (i % 2 == 1)) begin
                fails++;
                $display("FAIL contend_ready[%0d] got lsu=%0b exu=%0b want lsu=%0b exu=%0b",
                         i, lsu_ready, exu_ready, i % 2 == 0, i % 2 == 1);
            end
            tick();
            checks++;
            if (rf_waddr !== exp_rd[i] || rf_wdata !== exp_data[i] || retire_pc !== exp_pc[i]
                || rf_wen !== 1'b1) begin
                fails++;
                $display("FAIL contend_grant[%0d] got rd=%0d data=%h pc=%h wen=%0b want rd=%0d data=%h pc=%h wen=1",
                         i, rf_waddr, rf_wdata, retire_pc, rf_wen, exp_rd[i], exp_data[i], exp_pc[i]);
            end
            // Winner presents its next instruction; loser holds.
            if (i == 0) begin lsu_rd = 5'd11; lsu_data = 32'hA000_0001; lsu_pc = 32'h104; end
            if (i == 1) begin exu_rd = 5'd21; exu_data = 32'hB000_0001; exu_pc = 32'h204; end
        end
        lsu_valid = 1'b0; exu_valid = 1'b0;
        checks++; if (retire_cnt !== 32'd5) begin fails++; $display("FAIL contend_retire_cnt got %0d want 5", retire_cnt); end
        checks++; if (conflict_cnt !== 32'd4 * PerfScale) begin fails++; $display("FAIL contend_conflict_cnt got %0d want %0d", conflict_cnt, 32'd4 * PerfScale); end
    endtask

    task automatic test_x0_write();
        lsu_valid = 1'b1; lsu_rd = 5'd0; lsu_data = 32'hDEAD_BEEF; lsu_pc = 32'h300;
        tick();
        lsu_valid = 1'b0;
        checks++; if (rf_wen !== 1'b0) begin fails++; $display("FAIL x0_rf_wen got %0b want 0", rf_wen); end
        checks++; if (retire_valid !== 1'b1) begin fails++; $display("FAIL x0_retire_valid got %0b want 1", retire_valid); end
        checks++; if (retire_pc !== 32'h300) begin fails++; $display("FAIL x0_retire_pc got %h want 00000300", retire_pc); end
        checks++; if (rf_wdata !== 32'hDEAD_BEEF) begin fails++; $display("FAIL x0_rf_wdata got %h want deadbeef", rf_wdata); end
        checks++; if (retire_cnt !== 32'd6) begin fails++; $display("FAIL x0_retire_cnt got %0d want 6", retire_cnt); end
    endtask

    task automatic test_flush();
        // Priority now points at EXU after the LSU x0 retire.
        exu_valid = 1'b1; exu_rd = 5'd7; exu_data = 32'h77; exu_pc = 32'h400;
        lsu_valid = 1'b1; lsu_rd = 5'd8; lsu_data = 32'h88; lsu_pc = 32'h500;
        flush = 1'b1;
        #1;
        checks++; if (exu_ready !== 1'b0 || lsu_ready !== 1'b0) begin fails++; $display("FAIL flush_ready got exu=%0b lsu=%0b want 0 0", exu_ready, lsu_ready); end
        tick();
        flush = 1'b0;
        #1;
        checks++; if (retire_valid !== 1'b0 || rf_wen !== 1'b0) begin fails++; $display("FAIL flush_pulse got rv=%0b wen=%0b want 0 0", retire_valid, rf_wen); end
        checks++; if (retire_cnt !== 32'd6) begin fails++; $display("FAIL flush_retire_cnt got %0d want 6", retire_cnt); end
        checks++; if (conflict_cnt !== 32'd4 * PerfScale) begin fails++; $display("FAIL flush_conflict_cnt got %0d want %0d", conflict_cnt, 32'd4 * PerfScale); end
        checks++; if (lsu_ready !== 1'b1 || exu_ready !== 1'b0) begin fails++; $display("FAIL flush_prio_lsu got lsu=%0b exu=%0b want 1 0", lsu_ready, exu_ready); end
        exu_valid = 1'b0; lsu_valid = 1'b0;
        tick();
    endtask

    task automatic test_async_reset();
        exu_valid = 1'b1; lsu_valid = 1'b1;
        tick();
        tick();
        checks++; if (retire_cnt !== 32'd8) begin fails++; $display("FAIL b2b_retire_cnt got %0d want 8", retire_cnt); end
        checks++; if (conflict_cnt !== 32'd6 * PerfScale) begin fails++; $display("FAIL b2b_conflict_cnt got %0d want %0d", conflict_cnt, 32'd6 * PerfScale); end
        #1;
        rst_n = 1'b0;
        #1;
        checks++;
        if (rf_wen !== 1'b0 || retire_valid !== 1'b0 || rf_waddr !== 5'd0 || rf_wdata !== 32'd0
            || retire_pc !== 32'd0 || retire_cnt !== 32'd0 || conflict_cnt !== 32'd0) begin
            fails++;
            $display("FAIL async_reset_clear got wen=%0b rv=%0b wa=%0d wd=%h pc=%h rc=%0d cc=%0d want all 0",
                     rf_wen, retire_valid, rf_waddr, rf_wdata, retire_pc, retire_cnt, conflict_cnt);
        end
        exu_valid = 1'b0; lsu_valid = 1'b0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        checks++; if (retire_cnt !== 32'd0) begin fails++; $display("FAIL post_reset_retire_cnt got %0d want 0", retire_cnt); end
        exu_valid = 1'b1; lsu_valid = 1'b1;
        #1;
        checks++; if (lsu_ready !== 1'b1 || exu_ready !== 1'b0) begin fails++; $display("FAIL post_reset_prio got lsu=%0b exu=%0b want 1 0", lsu_ready, exu_ready); end
        exu_valid = 1'b0; lsu_valid = 1'b0;
    endtask

    initial begin
        test_reset();
        test_single_exu();
        test_contention();
        test_x0_write();
        test_flush();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
